diff_window_averager: RTL and testbench

DIFF_WINDOW_AVERAGER -- requirements
Module: diff_window_averager

---
 rtl/diff_window_averager.sv | 122 ++++++++++++
 tb/tb_diff_window_averager.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/diff_window_averager.sv
// Windowed mean and peak-magnitude of a signed difference stream, over N = 2^LOG2_N samples.
// Results are presented through a single-entry valid/ready holding register with a sticky overrun flag.
module diff_window_averager #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LOG2_N = 4
) (
    input  logic              M100CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_avg,
    output logic [DATA_W-1:0] out_peak,
    output logic              overrun,
    output logic [LOG2_N-1:0] fill
);

    localparam int unsigned ACC_W = DATA_W + LOG2_N;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [LOG2_N-1:0] fill_q, fill_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_avg_q, out_avg_d;
    logic [DATA_W-1:0] out_peak_q, out_peak_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic              complete;
    logic              load;
    logic              drop;
    logic [DATA_W-1:0] in_neg;
    logic [DATA_W-1:0] in_abs;
    logic [ACC_W-1:0]  in_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] peak_new;

    always_comb begin
        in_neg = '0 - in_data;
        // The most negative input has no positive counterpart; clamp it to the largest positive value.
        if (!in_data[DATA_W-1]) begin
            in_abs = in_data;
        end else if (in_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
            in_abs = {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            in_abs = in_neg;
        end

        in_ext   = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
        acc_sum  = acc_q + in_ext;
        peak_new = (in_abs > peak_q) ? in_abs : peak_q;

        accept   = in_valid && !clear;
        complete = accept && (fill_q == '1);
        load     = complete && (!out_valid_q || out_ready);
        drop     = complete && out_valid_q && !out_ready;
    end

    always_comb begin
        acc_d       = acc_q;
        peak_d      = peak_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_avg_d   = out_avg_q;
        out_peak_d  = out_peak_q;
        overrun_d   = overrun_q || drop;

        if (clear) begin
            acc_d     = '0;
            peak_d    = '0;
            fill_d    = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            fill_d = fill_q + 1'b1;
            if (complete) begin
                acc_d  = '0;
                peak_d = '0;
            end else begin
                acc_d  = acc_sum;
                peak_d = peak_new;
            end
        end

        // Dropping the low LOG2_N bits of the two's-complement sum is an arithmetic shift (floor).
        if (load) begin
            out_valid_d = 1'b1;
            out_avg_d   = acc_sum[ACC_W-1:LOG2_N];
            out_peak_d  = peak_new;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge M100CLK or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            peak_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_avg_q   <= '0;
            out_peak_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            peak_q      <= peak_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_avg_q   <= out_avg_d;
            out_peak_q  <= out_peak_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_avg   = out_avg_q;
    assign out_peak  = out_peak_q;
    assign overrun   = overrun_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_diff_window_averager.sv
// Scoreboard bench for diff_window_averager with a 4-sample window and hand-computed expectations.
module tb_diff_window_averager;

    localparam int unsigned DW = 32;
    localparam int unsigned LN = 2;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_avg;
    logic [DW-1:0] out_peak;
    logic          overrun;
    logic [LN-1:0] fill;

    typedef struct packed {
        logic [DW-1:0] avg;
        logic [DW-1:0] peak;
    } res_t;

    res_t sb[$];
    int   hs_cyc[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    diff_window_averager #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .M100CLK  (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clear    (clear),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_avg  (out_avg),
        .out_peak (out_peak),
        .overrun  (overrun),
        .fill     (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] avg, input logic [DW-1:0] peak);
        res_t r;
        r.avg  = avg;
        r.peak = peak;
        sb.push_back(r);
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result is checked against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got avg 0x%08h, expected no result", out_avg);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sb_avg", out_avg, e.avg);
                    chk("sb_peak", out_peak, e.peak);
                end
            end
        end
    end

    initial begin
        int n0;
        int waited;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_avg", out_avg, 32'd0);
        chk("rst_peak", out_peak, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_fill", {30'd0, fill}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // 4,8,-4,12: sum 20 -> avg 5, peak 12, valid right after the 4th sample
        push(32'd5, 32'd12);
        send(32'd4);
        send(32'd8);
        send(-32'sd4);
        chk("fill_after3", {30'd0, fill}, 32'd3);
        chk("no_early_valid", {31'd0, out_valid}, 32'd0);
        send(32'd12);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_wrap", {30'd0, fill}, 32'd0);
        tick();

        // -1,-1,-1,-2: sum -5 -> floor avg -2, peak 2
        push(32'hFFFF_FFFE, 32'd2);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFE);
        tick();

        // most negative value x4: avg stays most negative, peak saturates
        push(32'h8000_0000, 32'h7FFF_FFFF);
        repeat (4) send(32'h8000_0000);
        tick();

        // 12-sample burst 1..12: three windows with sums 10, 26, 42
        push(32'd2, 32'd4);
        push(32'd6, 32'd8);
        push(32'd10, 32'd12);
        tick();
        n0 = hs_cyc.size();
        for (int i = 1; i <= 12; i++) send(DW'(i));
        tick();
        chk("burst_pulses", DW'(hs_cyc.size() - n0), 32'd3);
        if (hs_cyc.size() - n0 == 3) begin
            chk("burst_gap1", DW'(hs_cyc[n0+1] - hs_cyc[n0]), 32'd4);
            chk("burst_gap2", DW'(hs_cyc[n0+2] - hs_cyc[n0+1]), 32'd4);
        end
        chk("burst_fill", {30'd0, fill}, 32'd0);

        // backpressure across two windows: first result held, second dropped
        out_ready = 1'b0;
        push(32'd2, 32'd4);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd4);
        repeat (4) send(32'd10);
        tick();
        chk("held_valid", {31'd0, out_valid}, 32'd1);
        chk("held_avg", out_avg, 32'd2);
        chk("held_peak", out_peak, 32'd4);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b1;
        chk("accept_drops_valid", {31'd0, out_valid}, 32'd0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        tick();
        chk("overrun_still", {31'd0, overrun}, 32'd1);

        // clear after two samples, then a window of 3s
        send(32'd100);
        send(-32'sd50);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_fill", {30'd0, fill}, 32'd0);
        chk("clear_overrun", {31'd0, overrun}, 32'd0);
        push(32'd3, 32'd3);
        repeat (4) send(32'd3);
        tick();

        // clear coincident with a sample: that sample is excluded
        clear = 1'b1;
        send(32'd1000);
        clear = 1'b0;
        chk("clear_ign_fill", {30'd0, fill}, 32'd0);
        push(32'd5, 32'd5);
        repeat (4) send(32'd5);
        tick();

        // async reset mid-window with a held result pending
        out_ready = 1'b0;
        repeat (4) send(32'd2);
        repeat (3) send(32'd9);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_reset_fill", {30'd0, fill}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_avg", out_avg, 32'd0);
        chk("async_peak", out_peak, 32'd0);
        chk("async_fill", {30'd0, fill}, 32'd0);
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        // -4,-8,4,0: sum -8 -> avg -2, peak 8
        push(32'hFFFF_FFFE, 32'd8);
        send(-32'sd4);
        send(-32'sd8);
        send(32'd4);
        send(32'd0);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        chk("sb_drained", DW'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
